// File: rtl/reg_file_pkg.sv
// Shared defaults for the register file with scoreboard: data/address widths
// and the index of the hardwired-zero register.
package reg_file_pkg;
   localparam int DEFAULT_DATA_W = 64;
   localparam int DEFAULT_ADDR_W = 5;
   localparam int XZR_INDEX      = 31;
endpackage

// File: rtl/reg_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register, set at issue and
// cleared at writeback, with set taking priority when both hit the same edge.
module reg_scoreboard
   import reg_file_pkg::*;
#(
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = XZR_INDEX
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_address,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_address,
   input  logic [ADDR_W-1:0] rd_address1,
   input  logic [ADDR_W-1:0] rd_address2,
   output logic              busy1,
   output logic              busy2
);
   localparam int                NREGS     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

   logic [NREGS-1:0] busy_r;

   // Per-register busy flag update; an issue to the zero register never sets it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_r <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (issue_valid && (issue_address == ADDR_W'(i)) && (issue_address != ZERO_ADDR)) begin
               busy_r[i] <= 1'b1;
            end else if (wb_valid && (wb_address == ADDR_W'(i))) begin
               busy_r[i] <= 1'b0;
            end
         end
      end
   end

   // Raw busy lookup for both read ports, zero register never busy.
   always_comb begin
      busy1 = 1'b0;
      busy2 = 1'b0;
      if (rd_address1 != ZERO_ADDR) begin
         busy1 = busy_r[rd_address1];
      end else begin
         busy1 = 1'b0;
      end
      if (rd_address2 != ZERO_ADDR) begin
         busy2 = busy_r[rd_address2];
      end else begin
         busy2 = 1'b0;
      end
   end
endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with hardwired-zero register, optional
// write-to-read forwarding and a busy-bit scoreboard driving the stall output.
module reg_file_sb
   import reg_file_pkg::*;
#(
   parameter int DATA_W   = DEFAULT_DATA_W,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter int ZERO_REG = XZR_INDEX,
   parameter int BYPASS   = 1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] readAddress1,
   input  logic [ADDR_W-1:0] readAddress2,
   output logic [DATA_W-1:0] regData1,
   output logic [DATA_W-1:0] regData2,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] writeAddress,
   input  logic [DATA_W-1:0] writeData,
   input  logic              issueValid,
   input  logic [ADDR_W-1:0] issueAddress,
   output logic              busy1,
   output logic              busy2,
   output logic              stall
);
   localparam int                NREGS     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
   localparam logic              BYP_EN    = (BYPASS != 0);

   logic [DATA_W-1:0] regs_r [NREGS];
   logic              sb_busy1_s;
   logic              sb_busy2_s;
   logic              hit1_s;
   logic              hit2_s;

   // Register storage; writes to the zero register are dropped.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else if (regWrite && (writeAddress != ZERO_ADDR)) begin
         regs_r[writeAddress] <= writeData;
      end
   end

   reg_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clock         (CLOCK),
      .reset         (RESET),
      .issue_valid   (issueValid),
      .issue_address (issueAddress),
      .wb_valid      (regWrite),
      .wb_address    (writeAddress),
      .rd_address1   (readAddress1),
      .rd_address2   (readAddress2),
      .busy1         (sb_busy1_s),
      .busy2         (sb_busy2_s)
   );

   // Forwarding hits; a zero-register address never forwards.
   always_comb begin
      hit1_s = BYP_EN && regWrite && (writeAddress == readAddress1) && (readAddress1 != ZERO_ADDR);
      hit2_s = BYP_EN && regWrite && (writeAddress == readAddress2) && (readAddress2 != ZERO_ADDR);
   end

   // Read port 1 data and busy, forced quiet while in reset.
   always_comb begin
      regData1 = '0;
      busy1    = 1'b0;
      if (RESET || (readAddress1 == ZERO_ADDR)) begin
         regData1 = '0;
         busy1    = 1'b0;
      end else if (hit1_s) begin
         regData1 = writeData;
         busy1    = 1'b0;
      end else begin
         regData1 = regs_r[readAddress1];
         busy1    = sb_busy1_s;
      end
   end

   // Read port 2 data and busy, mirror of port 1.
   always_comb begin
      regData2 = '0;
      busy2    = 1'b0;
      if (RESET || (readAddress2 == ZERO_ADDR)) begin
         regData2 = '0;
         busy2    = 1'b0;
      end else if (hit2_s) begin
         regData2 = writeData;
         busy2    = 1'b0;
      end else begin
         regData2 = regs_r[readAddress2];
         busy2    = sb_busy2_s;
      end
   end

   assign stall = busy1 | busy2;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a forwarding instance and a non-forwarding
// instance share one stimulus stream and are checked against hand-computed values.
module tb_reg_file_sb;
   logic        CLOCK;
   logic        RESET;
   logic [4:0]  readAddress1;
   logic [4:0]  readAddress2;
   logic        regWrite;
   logic [4:0]  writeAddress;
   logic [63:0] writeData;
   logic        issueValid;
   logic [4:0]  issueAddress;

   logic [63:0] regData1;
   logic [63:0] regData2;
   logic        busy1;
   logic        busy2;
   logic        stall;
   logic [63:0] nb_regData1;
   logic [63:0] nb_regData2;
   logic        nb_busy1;
   logic        nb_busy2;
   logic        nb_stall;

   int n_checks = 0;
   int n_errors = 0;

   reg_file_sb #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(1)) u_dut (
      .CLOCK(CLOCK), .RESET(RESET),
      .readAddress1(readAddress1), .readAddress2(readAddress2),
      .regData1(regData1), .regData2(regData2),
      .regWrite(regWrite), .writeAddress(writeAddress), .writeData(writeData),
      .issueValid(issueValid), .issueAddress(issueAddress),
      .busy1(busy1), .busy2(busy2), .stall(stall)
   );

   reg_file_sb #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(31), .BYPASS(0)) u_dut_nb (
      .CLOCK(CLOCK), .RESET(RESET),
      .readAddress1(readAddress1), .readAddress2(readAddress2),
      .regData1(nb_regData1), .regData2(nb_regData2),
      .regWrite(regWrite), .writeAddress(writeAddress), .writeData(writeData),
      .issueValid(issueValid), .issueAddress(issueAddress),
      .busy1(nb_busy1), .busy2(nb_busy2), .stall(nb_stall)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic idle();
      regWrite   = 1'b0;
      issueValid = 1'b0;
   endtask

   initial begin
      CLOCK        = 1'b0;
      RESET        = 1'b1;
      readAddress1 = 5'd1;
      readAddress2 = 5'd31;
      regWrite     = 1'b1;
      writeAddress = 5'd1;
      writeData    = 64'd9;
      issueValid   = 1'b1;
      issueAddress = 5'd1;

      // Held in reset: inputs ignored, outputs zero.
      step();
      #1;
      check("rst_data1", regData1, 64'd0);
      check("rst_busy1", {63'd0, busy1}, 64'd0);
      step();
      idle();
      RESET = 1'b0;
      #1;
      check("post_rst_data1", regData1, 64'd0);
      check("post_rst_data2", regData2, 64'd0);
      check("post_rst_stall", {63'd0, stall}, 64'd0);

      // Plain write then read next cycle; zero-register write discarded.
      regWrite = 1'b1; writeAddress = 5'd1; writeData = 64'd16;
      step();
      idle();
      #1;
      check("x1_read", regData1, 64'd16);
      check("x1_read_nb", nb_regData1, 64'd16);
      regWrite = 1'b1; writeAddress = 5'd31; writeData = 64'd5;
      readAddress2 = 5'd31;
      #1;
      check("xzr_no_bypass", regData2, 64'd0);
      step();
      idle();
      readAddress1 = 5'd31;
      #1;
      check("xzr_read", regData1, 64'd0);

      // Forwarding on vs off.
      regWrite = 1'b1; writeAddress = 5'd2; writeData = 64'd7;
      step();
      regWrite = 1'b1; writeAddress = 5'd2; writeData = 64'd12;
      readAddress2 = 5'd2;
      #1;
      check("bypass_data2", regData2, 64'd12);
      check("bypass_busy2", {63'd0, busy2}, 64'd0);
      check("nobypass_data2", nb_regData2, 64'd7);
      step();
      idle();
      #1;
      check("x2_after_wr", regData2, 64'd12);
      check("x2_after_wr_nb", nb_regData2, 64'd12);
      readAddress1 = 5'd2;
      #1;
      check("same_addr_ports", regData1, 64'd12);

      // Issue x3, observe busy, then writeback clears it.
      issueValid = 1'b1; issueAddress = 5'd3;
      step();
      idle();
      readAddress1 = 5'd3;
      #1;
      check("x3_busy1", {63'd0, busy1}, 64'd1);
      check("x3_stall", {63'd0, stall}, 64'd1);
      check("x3_busy1_nb", {63'd0, nb_busy1}, 64'd1);
      regWrite = 1'b1; writeAddress = 5'd3; writeData = 64'd3;
      #1;
      check("x3_wb_busy1", {63'd0, busy1}, 64'd0);
      check("x3_wb_stall", {63'd0, stall}, 64'd0);
      check("x3_wb_data1", regData1, 64'd3);
      check("x3_wb_busy1_nb", {63'd0, nb_busy1}, 64'd1);
      step();
      idle();
      #1;
      check("x3_busy_cleared", {63'd0, busy1}, 64'd0);
      check("x3_busy_cleared_nb", {63'd0, nb_busy1}, 64'd0);
      check("x3_data", regData1, 64'd3);

      // Same-edge writeback and issue: set wins.
      regWrite = 1'b1; writeAddress = 5'd4; writeData = 64'd4;
      issueValid = 1'b1; issueAddress = 5'd4;
      step();
      idle();
      readAddress1 = 5'd4;
      #1;
      check("x4_busy_set_wins", {63'd0, busy1}, 64'd1);
      check("x4_data", regData1, 64'd4);

      // Issue to the zero register never marks it busy.
      issueValid = 1'b1; issueAddress = 5'd31;
      step();
      idle();
      readAddress2 = 5'd31;
      #1;
      check("xzr_not_busy", {63'd0, busy2}, 64'd0);

      // Async reset mid-run.
      regWrite = 1'b1; writeAddress = 5'd5; writeData = 64'd5;
      step();
      idle();
      issueValid = 1'b1; issueAddress = 5'd5;
      step();
      idle();
      readAddress1 = 5'd5;
      readAddress2 = 5'd1;
      #1;
      check("x5_pre_rst_data", regData1, 64'd5);
      check("x5_pre_rst_busy", {63'd0, busy1}, 64'd1);
      RESET = 1'b1;
      #1;
      check("async_rst_data1", regData1, 64'd0);
      check("async_rst_busy1", {63'd0, busy1}, 64'd0);
      check("async_rst_stall", {63'd0, stall}, 64'd0);
      regWrite = 1'b1; writeAddress = 5'd5; writeData = 64'd99;
      issueValid = 1'b1; issueAddress = 5'd5;
      step();
      idle();
      #1;
      RESET = 1'b0;
      #1;
      check("rst_release_data1", regData1, 64'd0);
      check("rst_release_busy1", {63'd0, busy1}, 64'd0);
      check("rst_release_x1", regData2, 64'd0);

      // First edge after reset accepts writes.
      regWrite = 1'b1; writeAddress = 5'd7; writeData = 64'd77;
      step();
      idle();
      readAddress1 = 5'd7;
      #1;
      check("x7_after_rst", regData1, 64'd77);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
